hashmap_ctrl: RTL
=================

// Module: hashmap_ctrl
// PURPOSE
//  Front-end scheduler for the cuckoo hash table (chain of columns sharing one lookup pipe).
//  Arbitrates lookup/update/delete requests against insert requests, drives the columns'
//  lookup/modify/del strobes at fixed NUM_PIPES latency, and closes the eviction loop.
//  Bounds each cuckoo kick chain and reports insert completion or failure.
// PARAMETERS
//  NUM_KEY_BITS  8   key width
//  NUM_VAL_BITS  8   value width
//  NUM_PIPES     1   column lookup latency (cycles), >=1
//  MAX_KICKS     16  loop evictions allowed per insert chain before the chain is dropped
//  SETTLE_CYC    8   idle cycles with no loop eviction before a chain is declared done, >=NUM_PIPES+1
//  LU_BURST      4   max back-to-back lookup issues before one forced insert slot
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous active-high reset
//  req_valid     in   1    request offered
//  req_ready     out  1    request accepted this cycle when req_valid&&req_ready
//  req_op        in   2    0=LOOKUP 1=UPDATE 2=DELETE 3=reserved (treated as LOOKUP)
//  req_key       in   NUM_KEY_BITS   request key
//  req_value     in   NUM_VAL_BITS   new value for UPDATE
//  resp_valid    out  1    response strobe, NUM_PIPES cycles after acceptance; no backpressure
//  resp_hit      out  1    key found
//  resp_value    out  NUM_VAL_BITS   value found (pre-modify); 0 on miss
//  ins_valid     in   1    insert offered
//  ins_ready     out  1    insert accepted when ins_valid&&ins_ready
//  ins_key       in   NUM_KEY_BITS   insert key
//  ins_value     in   NUM_VAL_BITS   insert value
//  ins_done      out  1    1-cycle pulse: chain settled, all entries resident
//  ins_fail      out  1    1-cycle pulse: chain exceeded MAX_KICKS, one entry dropped
//  col_lookup    out  1    to all columns: lookup
//  col_lu_key    out  NUM_KEY_BITS   to all columns: lookup key
//  col_modify    out  1    to all columns: modify (NUM_PIPES after lookup)
//  col_del       out  1    to all columns: delete qualifier
//  col_mod_value out  NUM_VAL_BITS   to all columns: new value
//  col_match     out  1    to all columns match_in = OR of column lu_valid
//  col_busy      in   1    OR of column busy
//  col_lu_valid  in   1    OR of column lu_valid
//  col_lu_value  in   NUM_VAL_BITS   value from the hitting column
//  ev_loop_valid in   1    eviction out of last column
//  ev_loop_key   in   NUM_KEY_BITS
//  ev_loop_value in   NUM_VAL_BITS
//  ev_in_valid   out  1    eviction/insert into first column
//  ev_key_in     out  NUM_KEY_BITS
//  ev_value_in   out  NUM_VAL_BITS
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, lookup pipe valids cleared; in-flight responses discarded.
//  Request path: req_ready = !rst && !force_slot. Accept -> col_lookup=1 same cycle (comb),
//   col_lu_key=req_key; op/value/key enter an NUM_PIPES-deep shift pipe.
//  At pipe exit: resp_valid=1, resp_hit=col_lu_valid, resp_value=hit?col_lu_value:0;
//   col_match=col_lu_valid; col_modify=hit&&op in{UPDATE,DELETE}; col_del=(op==DELETE);
//   col_mod_value=stored req_value. All col_* zero when pipe-exit slot empty.
//  Fairness: burst counter counts consecutive lookup cycles; at LU_BURST, force_slot=1 for one
//   cycle (req_ready=0) iff FSM!=IDLE or ins_valid; counter clears on any non-lookup cycle.
//  Eviction mux (only when col_lookup=0 && col_busy=0, else ev_in_valid=0):
//   priority 1 ev_loop_valid -> forward loop eviction; priority 2 accepted insert.
//   ev_loop_valid while col_lookup||col_busy: columns hold it; controller forwards next legal cycle.
//  ins_ready = FSM==IDLE && !col_lookup && !col_busy && !ev_loop_valid.
//  FSM: IDLE -ins accept-> CHAIN (kicks=0, settle=SETTLE_CYC).
//   CHAIN: forwarded loop eviction -> kicks+1, settle reload; kicks==MAX_KICKS on a loop
//    eviction -> ev_in_valid=0 (entry dropped), -> DRAIN. No eviction -> settle-1;
//    settle==0 -> ins_done, ->IDLE.
//   DRAIN: as CHAIN but loop evictions are forwarded without counting; settle==0 -> ins_fail, ->IDLE.
//  Simultaneous ins accept and ev_loop_valid impossible (ins_ready gated). Kick counter
//   saturates at MAX_KICKS; width $clog2(MAX_KICKS+1).
//  Reset mid-chain: FSM->IDLE, no done/fail pulse; table contents not this block's concern.
// CONFIGURATION
//  HASHMAP_CTRL_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_kicks, stat_fails
//   (32 bit each, saturating, cleared by rst), counted on resp_valid/forwarded kick/ins_fail.
//  Undefined: ports absent, no counters; all other behaviour identical.
// TESTING
//  1 NUM_PIPES=2: insert k=0x12 v=0x34 -> ins_done after SETTLE_CYC; LOOKUP 0x12 -> resp t+2 hit=1 value=0x34.
//  2 UPDATE 0x12 v=0x56 -> col_modify=1,col_del=0,col_mod_value=0x56 at t+2; next LOOKUP returns 0x56.
//  3 DELETE 0x12 -> col_del=1 at t+2; LOOKUP 0x12 -> hit=0 value=0; LOOKUP 0x99 miss -> col_modify=0.
//  4 req_valid held 20 cycles with ins_valid=1, LU_BURST=4 -> req_ready low every 5th cycle, insert accepted there.
//  5 colliding keys with MAX_KICKS=2 -> 3rd loop eviction dropped, ev_in_valid=0, ins_fail pulse once, FSM IDLE.
//  6 rst asserted in CHAIN with response pending -> next cycle all outputs 0, no resp_valid/ins_done afterwards.

Source files
------------

// File: rtl/hashmap_ctrl.sv
// hashmap_ctrl: request/insert scheduler and cuckoo eviction-loop controller for a column chain.
// Define HASHMAP_CTRL_STATS_EN to add saturating hit/miss/kick/fail counters.
module hashmap_ctrl #(
    parameter int unsigned NUM_KEY_BITS = 8,
    parameter int unsigned NUM_VAL_BITS = 8,
    parameter int unsigned NUM_PIPES    = 1,
    parameter int unsigned MAX_KICKS    = 16,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned LU_BURST     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [NUM_KEY_BITS-1:0] req_key,
    input  logic [NUM_VAL_BITS-1:0] req_value,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [NUM_VAL_BITS-1:0] resp_value,
    input  logic                    ins_valid,
    output logic                    ins_ready,
    input  logic [NUM_KEY_BITS-1:0] ins_key,
    input  logic [NUM_VAL_BITS-1:0] ins_value,
    output logic                    ins_done,
    output logic                    ins_fail,
    output logic                    col_lookup,
    output logic [NUM_KEY_BITS-1:0] col_lu_key,
    output logic                    col_modify,
    output logic                    col_del,
    output logic [NUM_VAL_BITS-1:0] col_mod_value,
    output logic                    col_match,
    input  logic                    col_busy,
    input  logic                    col_lu_valid,
    input  logic [NUM_VAL_BITS-1:0] col_lu_value,
    input  logic                    ev_loop_valid,
    input  logic [NUM_KEY_BITS-1:0] ev_loop_key,
    input  logic [NUM_VAL_BITS-1:0] ev_loop_value,
    output logic                    ev_in_valid,
    output logic [NUM_KEY_BITS-1:0] ev_key_in,
    output logic [NUM_VAL_BITS-1:0] ev_value_in
`ifdef HASHMAP_CTRL_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses,
    output logic [31:0]             stat_kicks,
    output logic [31:0]             stat_fails
`endif
);

    localparam int unsigned KickW   = $clog2(MAX_KICKS + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned BurstW  = $clog2(LU_BURST + 1);
    localparam logic [1:0]  OpUpdate = 2'd1;
    localparam logic [1:0]  OpDelete = 2'd2;

    typedef enum logic [1:0] {StIdle, StChain, StDrain} state_e;

    state_e                   state_q;
    logic [KickW-1:0]         kicks_q;
    logic [SettleW-1:0]       settle_q;
    logic [BurstW-1:0]        burst_q;
    logic [NUM_PIPES-1:0]     pv_q;
    logic [1:0]               pop_q  [NUM_PIPES];
    logic [NUM_VAL_BITS-1:0]  pval_q [NUM_PIPES];

    logic force_slot, accept, ex_v, ev_legal, loop_evt, drop, fwd_loop, ins_accept;
    logic [1:0] ex_op;

    // Request side
    assign force_slot = (burst_q == BurstW'(LU_BURST)) && ((state_q != StIdle) || ins_valid);
    assign req_ready  = !rst && !force_slot;
    assign accept     = req_valid && req_ready;
    assign col_lookup = accept;
    assign col_lu_key = accept ? req_key : '0;

    assign ex_v  = pv_q[NUM_PIPES-1] && !rst;
    assign ex_op = pop_q[NUM_PIPES-1];

    assign resp_valid    = ex_v;
    assign resp_hit      = ex_v && col_lu_valid;
    assign resp_value    = resp_hit ? col_lu_value : '0;
    assign col_match     = resp_hit;
    assign col_modify    = resp_hit && ((ex_op == OpUpdate) || (ex_op == OpDelete));
    assign col_del       = ex_v && (ex_op == OpDelete);
    assign col_mod_value = ex_v ? pval_q[NUM_PIPES-1] : '0;

    // Eviction side: the first column only takes a key when the shared pipe is quiet
    assign ev_legal   = !rst && !col_lookup && !col_busy;
    assign loop_evt   = ev_legal && ev_loop_valid;
    assign drop       = loop_evt && (state_q == StChain) && (kicks_q == KickW'(MAX_KICKS));
    assign fwd_loop   = loop_evt && !drop;
    assign ins_ready  = !rst && (state_q == StIdle) && !col_lookup && !col_busy && !ev_loop_valid;
    assign ins_accept = ins_valid && ins_ready;

    assign ev_in_valid = fwd_loop || ins_accept;
    assign ev_key_in   = fwd_loop ? ev_loop_key : (ins_accept ? ins_key : '0);
    assign ev_value_in = fwd_loop ? ev_loop_value : (ins_accept ? ins_value : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int i = 1; i < NUM_PIPES; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pop_q[0]  <= req_op;
        pval_q[0] <= req_value;
        for (int i = 1; i < NUM_PIPES; i++) begin
            pop_q[i]  <= pop_q[i-1];
            pval_q[i] <= pval_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else if (col_lookup) begin
            if (burst_q != BurstW'(LU_BURST)) begin
                burst_q <= burst_q + BurstW'(1);
            end
        end else begin
            burst_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            kicks_q  <= '0;
            settle_q <= '0;
            ins_done <= 1'b0;
            ins_fail <= 1'b0;
        end else begin
            ins_done <= 1'b0;
            ins_fail <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ins_accept) begin
                        state_q  <= StChain;
                        kicks_q  <= '0;
                        settle_q <= SettleW'(SETTLE_CYC);
                    end
                end
                StChain, StDrain: begin
                    if (loop_evt) begin
                        settle_q <= SettleW'(SETTLE_CYC);
                        if (drop) begin
                            state_q <= StDrain;
                        end else if (state_q == StChain) begin
                            kicks_q <= kicks_q + KickW'(1);
                        end
                    end else if (settle_q == '0) begin
                        ins_done <= (state_q == StChain);
                        ins_fail <= (state_q == StDrain);
                        state_q  <= StIdle;
                    end else begin
                        settle_q <= settle_q - SettleW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef HASHMAP_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_kicks  <= '0;
            stat_fails  <= '0;
        end else begin
            if (resp_hit && (stat_hits != '1)) stat_hits <= stat_hits + 32'd1;
            if (resp_valid && !resp_hit && (stat_misses != '1)) stat_misses <= stat_misses + 32'd1;
            if (fwd_loop && (stat_kicks != '1)) stat_kicks <= stat_kicks + 32'd1;
            if (ins_fail && (stat_fails != '1)) stat_fails <= stat_fails + 32'd1;
        end
    end
`endif

endmodule
